// File: rtl/unibus_dma_master_pkg.sv
// Shared definitions for the Unibus NPR DMA master: FSM states, C1:C0 cycle codes
// and the fixed register words returned on the ARM read bus.
package unibus_dma_master_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_DRIVE,
        S_MSYN,
        S_WAIT,
        S_END,
        S_REL,
        S_FIN
    } dma_state_t;

    localparam logic [1:0] C_DATI  = 2'b00;
    localparam logic [1:0] C_DATIP = 2'b01;
    localparam logic [1:0] C_DATO  = 2'b10;
    localparam logic [1:0] C_DATOB = 2'b11;

    localparam logic [31:0] DM_IDENT = 32'h444D1001;
    localparam logic [31:0] DM_NOREG = 32'hDEADBEEF;

endpackage

// File: rtl/unibus_dma_master.sv
// Unibus NPR bus master: runs one single-word DATI/DATIP/DATO/DATOB cycle per ARM go
// command, with the same armwrite/armraddr register bus as the slave device blocks.
module unibus_dma_master
    import unibus_dma_master_pkg::*;
#(
    parameter logic [7:0]  DESKEW  = 8'd15,
    parameter logic [7:0]  SETTLE  = 8'd8,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        init_in_h,
    input  logic        npg_in_h,
    input  logic        bbsy_in_h,
    input  logic        ssyn_in_h,
    input  logic [15:0] d_in_h,
    output logic        npr_out_h,
    output logic        sack_out_h,
    output logic        bbsy_out_h,
    output logic        msyn_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h
);

    localparam logic [15:0] DESKEW_LAST = {8'd0, DESKEW} - 16'd1;
    localparam logic [15:0] SETTLE_LAST = {8'd0, SETTLE} - 16'd1;

    dma_state_t  state;
    logic [15:0] tcnt;
    logic        busy;
    logic        err;
    logic        done;
    logic        tmo_grant;
    logic        tmo_ssyn;
    logic [1:0]  cmd_c;
    logic [17:0] cmd_addr;
    logic [15:0] rdata;
    logic [15:0] wdata;

    logic go_wr;
    logic is_write;
    logic unused_wdata_bits;

    assign go_wr    = armwrite && (armwaddr == 3'd1) && armwdata[31];
    assign is_write = (cmd_c == C_DATO) || (cmd_c == C_DATOB);
    assign unused_wdata_bits = ^{armwdata[30:26], armwdata[23:18]};

    always_comb begin
        armrdata = DM_NOREG;
        case (armraddr)
            3'd0:    armrdata = DM_IDENT;
            3'd1:    armrdata = {busy, err, done, tmo_grant, tmo_ssyn, 1'b0, cmd_c,
                                 6'b0, cmd_addr};
            3'd2:    armrdata = {rdata, wdata};
            default: armrdata = DM_NOREG;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            tcnt       <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
            tmo_grant  <= 1'b0;
            tmo_ssyn   <= 1'b0;
            cmd_c      <= '0;
            cmd_addr   <= '0;
            rdata      <= '0;
            wdata      <= '0;
            npr_out_h  <= 1'b0;
            sack_out_h <= 1'b0;
            bbsy_out_h <= 1'b0;
            msyn_out_h <= 1'b0;
            a_out_h    <= '0;
            c_out_h    <= '0;
            d_out_h    <= '0;
        end else begin
            if (armwrite && (armwaddr == 3'd2))
                wdata <= armwdata[15:0];

            if (init_in_h) begin
                // Bus INIT drops everything we drive and fails any cycle in progress.
                state      <= S_IDLE;
                tcnt       <= '0;
                npr_out_h  <= 1'b0;
                sack_out_h <= 1'b0;
                bbsy_out_h <= 1'b0;
                msyn_out_h <= 1'b0;
                a_out_h    <= '0;
                c_out_h    <= '0;
                d_out_h    <= '0;
                if (busy) begin
                    err  <= 1'b1;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end else begin
                if (tcnt != 16'hFFFF)
                    tcnt <= tcnt + 16'd1;

                case (state)
                    S_IDLE: begin
                        if (go_wr) begin
                            cmd_c     <= armwdata[25:24];
                            cmd_addr  <= armwdata[17:0];
                            err       <= 1'b0;
                            done      <= 1'b0;
                            tmo_grant <= 1'b0;
                            tmo_ssyn  <= 1'b0;
                            busy      <= 1'b1;
                            npr_out_h <= 1'b1;
                            tcnt      <= '0;
                            state     <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (npg_in_h) begin
                            npr_out_h  <= 1'b0;
                            sack_out_h <= 1'b1;
                            tcnt       <= '0;
                            state      <= S_ACK;
                        end else if (tcnt == TIMEOUT) begin
                            npr_out_h <= 1'b0;
                            err       <= 1'b1;
                            tmo_grant <= 1'b1;
                            tcnt      <= '0;
                            state     <= S_FIN;
                        end
                    end
                    S_ACK: begin
                        // Bus is ours once the grant is gone and the previous master has let go.
                        if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) begin
                            bbsy_out_h <= 1'b1;
                            a_out_h    <= cmd_addr;
                            c_out_h    <= cmd_c;
                            d_out_h    <= is_write ? wdata : 16'd0;
                            tcnt       <= '0;
                            state      <= S_DRIVE;
                        end
                    end
                    S_DRIVE: begin
                        if (tcnt == DESKEW_LAST) begin
                            msyn_out_h <= 1'b1;
                            sack_out_h <= 1'b0;
                            tcnt       <= '0;
                            state      <= S_MSYN;
                        end
                    end
                    S_MSYN: begin
                        if (ssyn_in_h) begin
                            tcnt  <= '0;
                            state <= S_WAIT;
                        end else if (tcnt == TIMEOUT) begin
                            msyn_out_h <= 1'b0;
                            err        <= 1'b1;
                            tmo_ssyn   <= 1'b1;
                            tcnt       <= '0;
                            state      <= S_END;
                        end
                    end
                    S_WAIT: begin
                        if (tcnt == SETTLE_LAST) begin
                            if (!is_write)
                                rdata <= d_in_h;
                            msyn_out_h <= 1'b0;
                            tcnt       <= '0;
                            state      <= S_END;
                        end
                    end
                    S_END: begin
                        if (!ssyn_in_h || err) begin
                            bbsy_out_h <= 1'b0;
                            a_out_h    <= '0;
                            c_out_h    <= '0;
                            d_out_h    <= '0;
                            tcnt       <= '0;
                            state      <= S_REL;
                        end
                    end
                    S_REL: begin
                        tcnt  <= '0;
                        state <= S_FIN;
                    end
                    S_FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        tcnt  <= '0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_unibus_dma_master.sv
// Directed bench for unibus_dma_master with a small arbiter/slave model on the bus side.
module tb_unibus_dma_master;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        armwrite = 1'b0;
    logic [2:0]  armraddr = 3'd1;
    logic [2:0]  armwaddr = 3'd0;
    logic [31:0] armwdata = '0;
    logic [31:0] armrdata;
    logic        init_in_h = 1'b0;
    logic        npg_in_h = 1'b0;
    logic        bbsy_in_h = 1'b0;
    logic        ssyn_in_h = 1'b0;
    logic [15:0] d_in_h = '0;
    logic        npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;

    unibus_dma_master dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
        .armwdata(armwdata), .armrdata(armrdata),
        .init_in_h(init_in_h), .npg_in_h(npg_in_h), .bbsy_in_h(bbsy_in_h),
        .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h),
        .npr_out_h(npr_out_h), .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h),
        .msyn_out_h(msyn_out_h), .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h)
    );

    always #5 CLOCK = ~CLOCK;

    int n_chk = 0;
    int n_pass = 0;

    // bus model controls and observations
    logic        grant_en = 1'b1;
    logic        slave_en = 1'b1;
    logic [15:0] slave_data = '0;
    logic [15:0] slave_got = '0;
    int          gcnt = 0;
    int          stable_cnt = 0;
    int          msyn_stable = 0;
    int          bbsy_bad = 0;
    logic [17:0] msyn_a = '0;
    logic [1:0]  msyn_c = '0;
    logic [15:0] msyn_d = '0;
    logic [35:0] prev_bus = '0;
    logic        prev_msyn = 1'b0;
    logic        prev_bbsy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge CLOCK); #1;
        armwaddr = a; armwdata = d; armwrite = 1'b1;
        @(posedge CLOCK); #1;
        armwrite = 1'b0;
    endtask

    task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
        armraddr = a;
        #1;
        d = armrdata;
        armraddr = 3'd1;
        #1;
    endtask

    task automatic wait_done(input string tag, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLOCK);
            if (armrdata[29]) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    // Arbiter grants 5 cycles after NPR; slave answers MSYN with SSYN and read data.
    initial begin : bus_model
        forever begin
            @(posedge CLOCK); #1;
            if (!bbsy_out_h) stable_cnt = 0;
            else if ({a_out_h, c_out_h, d_out_h} != prev_bus) stable_cnt = 0;
            else stable_cnt++;
            prev_bus = {a_out_h, c_out_h, d_out_h};
            if (msyn_out_h && !prev_msyn) begin
                msyn_a = a_out_h; msyn_c = c_out_h; msyn_d = d_out_h;
                msyn_stable = stable_cnt;
            end
            if (!bbsy_out_h && prev_bbsy && (msyn_out_h || ssyn_in_h || prev_msyn))
                bbsy_bad++;
            prev_msyn = msyn_out_h;
            prev_bbsy = bbsy_out_h;

            if (!npr_out_h) gcnt = 0;
            else if (grant_en && !npg_in_h) begin
                if (gcnt == 5) npg_in_h = 1'b1;
                else gcnt++;
            end
            if (sack_out_h) npg_in_h = 1'b0;

            if (slave_en && msyn_out_h && !ssyn_in_h) begin
                ssyn_in_h = 1'b1;
                d_in_h    = slave_data;
                slave_got = d_out_h;
            end
            if (!msyn_out_h) begin
                ssyn_in_h = 1'b0;
                d_in_h    = '0;
            end
        end
    end

    initial begin : main
        logic [31:0] rv;
        logic        seen;

        repeat (3) @(posedge CLOCK);
        #1 RESET = 1'b0;
        @(negedge CLOCK);
        arm_rd(3'd0, rv); check("ident", rv, 32'h444D1001);
        arm_rd(3'd1, rv); check("r1_reset", rv, 32'h0);
        arm_rd(3'd2, rv); check("r2_reset", rv, 32'h0);
        arm_rd(3'd5, rv); check("noreg", rv, 32'hDEADBEEF);
        check("bus_reset", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, 8'd0, a_out_h,
                            c_out_h}, 32'h0);
        check("dout_reset", {16'd0, d_out_h}, 32'h0);

        // DATO to 0o010000
        arm_wr(3'd2, 32'h0000_1234);
        arm_wr(3'd1, 32'h8200_1000);
        @(negedge CLOCK);
        check("dato_busy", {31'd0, armrdata[31]}, 32'd1);
        wait_done("dato_done", 3000);
        check("dato_addr", {14'd0, msyn_a}, 32'o010000);
        check("dato_c", {30'd0, msyn_c}, 32'd2);
        check("dato_dout", {16'd0, msyn_d}, 32'h1234);
        check("dato_deskew", {31'd0, (msyn_stable >= 15)}, 32'd1);
        check("dato_slave", {16'd0, slave_got}, 32'h1234);
        check("dato_r1", armrdata, 32'h2200_1000);
        check("dato_bus_idle", {28'd0, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h}, 32'h0);

        // DATI from 0x200
        bbsy_bad = 0;
        slave_data = 16'hBEEF;
        arm_wr(3'd1, 32'h8000_0200);
        wait_done("dati_done", 3000);
        check("dati_r1", armrdata, 32'h2000_0200);
        arm_rd(3'd2, rv); check("dati_r2", rv, 32'hBEEF_1234);
        check("dati_dout", {16'd0, msyn_d}, 32'h0);
        check("dati_bbsy_order", bbsy_bad, 0);

        // Grant timeout
        grant_en = 1'b0;
        arm_wr(3'd1, 32'h8000_0100);
        repeat (900) @(negedge CLOCK);
        check("gto_early", {30'd0, armrdata[29], npr_out_h}, 32'd1);
        wait_done("gto_done", 300);
        check("gto_r1", armrdata, 32'h7000_0100);
        check("gto_npr", {31'd0, npr_out_h}, 32'd0);
        grant_en = 1'b1;

        // SSYN timeout
        slave_en = 1'b0;
        arm_wr(3'd1, 32'h8200_0040);
        wait_done("sto_done", 3000);
        check("sto_r1", armrdata, 32'h6A00_0040);
        check("sto_bus", {28'd0, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h}, 32'h0);

        // INIT during MSYN
        arm_wr(3'd1, 32'h8200_0300);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLOCK);
            if (msyn_out_h) begin seen = 1'b1; break; end
        end
        check("init_msyn_seen", {31'd0, seen}, 32'd1);
        @(posedge CLOCK); #1 init_in_h = 1'b1;
        @(posedge CLOCK); #1 init_in_h = 1'b0;
        @(negedge CLOCK);
        check("init_bus", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, 8'd0, a_out_h,
                           c_out_h}, 32'h0);
        check("init_dout", {16'd0, d_out_h}, 32'h0);
        check("init_r1", armrdata, 32'h6200_0300);
        slave_en = 1'b1;
        arm_wr(3'd1, 32'h8200_0302);
        wait_done("post_init_done", 3000);
        check("post_init_r1", armrdata, 32'h2200_0302);

        // Go while busy is ignored, then DATOB to an odd address
        slave_data = 16'h5555;
        arm_wr(3'd1, 32'h8000_0400);
        repeat (3) @(negedge CLOCK);
        arm_wr(3'd1, 32'h8300_0777);
        wait_done("busy_done", 3000);
        check("busy_r1", armrdata, 32'h2000_0400);
        arm_rd(3'd2, rv); check("busy_r2", rv, 32'h5555_1234);
        arm_wr(3'd2, 32'h0000_00AB);
        arm_wr(3'd1, 32'h8300_0777);
        wait_done("datob_done", 3000);
        check("datob_c", {30'd0, msyn_c}, 32'd3);
        check("datob_a0", {31'd0, msyn_a[0]}, 32'd1);
        check("datob_addr", {14'd0, msyn_a}, 32'h777);
        check("datob_dout", {16'd0, msyn_d}, 32'h00AB);
        check("datob_r1", armrdata, 32'h2300_0777);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
